ps2_kbd_ctrl: RTL and testbench

Keyboard-side controller sitting directly behind the PS/2 byte receiver. It gates the receiver through rx_en, assembles raw scancode bytes (E0/F0/E1 prefixes) into single key events, and buffers the events in a small FIFO with a valid/ready interface toward the character/display logic. It provides inter-byte timeout recovery and sticky overflow reporting.

---
 rtl/ps2_kbd_ctrl.sv | 130 +++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: assembles PS/2 scancode bytes into key events and buffers them in a FWFT FIFO
// with receiver gating, inter-byte timeout recovery and sticky overflow.
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       overflow,
    input  logic       clr_overflow,
    output logic       timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] RX_MAX   = CW'(FIFO_DEPTH - 2);

    typedef enum logic [2:0] {P_IDLE, P_E0, P_F0, P_E0F0, P_PAUSE} state_t;

    state_t          r_state, w_state_nx;
    logic [2:0]      r_skip, w_skip_nx;
    logic [TW-1:0]   r_tmo, w_tmo_nx;
    logic            w_tmo_hit, w_drop, w_push;
    logic [9:0]      w_push_data;

    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr, r_rd;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic            w_full, w_pop, w_wr;

    assign w_drop = rx_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    always_comb begin
        w_state_nx  = r_state;
        w_skip_nx   = r_skip;
        w_push      = 1'b0;
        w_push_data = {2'b00, rx_data};
        w_tmo_hit   = (r_state != P_IDLE) && !rx_done_tick && (r_tmo == TMO_LAST);
        w_tmo_nx    = (rx_done_tick || r_state == P_IDLE) ? '0 : r_tmo + 1'b1;
        if (w_tmo_hit) begin
            w_state_nx = P_IDLE;
            w_tmo_nx   = '0;
        end else if (rx_done_tick) begin
            case (r_state)
                P_IDLE: begin
                    if (rx_data == 8'hE0) w_state_nx = P_E0;
                    else if (rx_data == 8'hF0) w_state_nx = P_F0;
                    else if (rx_data == 8'hE1) begin
                        w_state_nx = P_PAUSE;
                        w_skip_nx  = 3'd7;
                    end else w_push = !w_drop;
                end
                P_E0: begin
                    if (rx_data == 8'hF0) w_state_nx = P_E0F0;
                    else if (rx_data != 8'hE0) begin
                        w_push      = 1'b1;
                        w_push_data = {2'b10, rx_data};
                        w_state_nx  = P_IDLE;
                    end
                end
                P_F0: begin
                    w_push      = 1'b1;
                    w_push_data = {2'b01, rx_data};
                    w_state_nx  = P_IDLE;
                end
                P_E0F0: begin
                    w_push      = 1'b1;
                    w_push_data = {2'b11, rx_data};
                    w_state_nx  = P_IDLE;
                end
                P_PAUSE: begin
                    // Pause is reported as a single extended E1 make event
                    w_skip_nx = r_skip - 1'b1;
                    if (r_skip == 3'd1) begin
                        w_push      = 1'b1;
                        w_push_data = {2'b10, 8'hE1};
                        w_state_nx  = P_IDLE;
                    end
                end
                default: w_state_nx = P_IDLE;
            endcase
        end
    end

    assign ev_valid = (r_cnt != '0);
    assign {ev_ext, ev_break, ev_code} = ev_valid ? r_mem[r_rd] : 10'd0;
    assign w_full   = (r_cnt == CNT_FULL);
    assign w_pop    = ev_valid & ev_ready;
    assign w_wr     = w_push & (~w_full | w_pop);
    assign w_cnt_nx = r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= w_push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= P_IDLE;
            r_skip      <= '0;
            r_tmo       <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
            rx_en       <= 1'b1;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_skip      <= w_skip_nx;
            r_tmo       <= w_tmo_nx;
            r_wr        <= w_wr ? r_wr + 1'b1 : r_wr;
            r_rd        <= w_pop ? r_rd + 1'b1 : r_rd;
            r_cnt       <= w_cnt_nx;
            // two free slots leave room for a frame already on the wire
            rx_en       <= (w_cnt_nx <= RX_MAX);
            overflow    <= (w_push & w_full & ~w_pop) | (overflow & ~clr_overflow);
            timeout_err <= w_tmo_hit;
        end
    end
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: scoreboard bench for ps2_kbd_ctrl (FIFO_DEPTH=4, TIMEOUT_CYCLES=16).
module tb_ps2_kbd_ctrl;
    logic       clk = 0;
    logic       reset = 0;
    logic       rx_done_tick = 0;
    logic [7:0] rx_data = 0;
    logic       ev_ready = 1;
    logic       clr_overflow = 0;
    logic       rx_en, ev_valid, ev_ext, ev_break, overflow, timeout_err;
    logic [7:0] ev_code;
    logic [9:0] q[$];
    int         n_chk = 0;
    int         n_err = 0;

    ps2_kbd_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .rx_en(rx_en), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_ext(ev_ext), .ev_break(ev_break), .overflow(overflow),
        .clr_overflow(clr_overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1 rx_done_tick = 1; rx_data = b;
        @(posedge clk); #1 rx_done_tick = 0;
    endtask

    task automatic send_ev(input logic [7:0] b, input logic [9:0] e);
        q.push_back(e);
        send(b);
    endtask

    always @(negedge clk) begin
        if (reset && ev_valid && ev_ready) begin
            if (q.size() == 0) chk("sb_under", q.size(), 1);
            else chk("ev", {ev_ext, ev_break, ev_code}, q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pause_seq [7] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0};
        int pulses, first;
        logic seen_ev;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", ev_valid, 0);
        chk("rst_rx_en", rx_en, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_code", {ev_ext, ev_break, ev_code}, 0);
        reset = 1;
        // make / break
        send_ev(8'h1C, 10'h01C);
        chk("lat_make", ev_valid, 1);
        send(8'hF0);
        chk("pfx_f0", ev_valid, 0);
        send_ev(8'h1C, 10'h11C);
        chk("lat_break", ev_valid, 1);
        // extended make / break, ignored bytes
        send(8'hE0);
        chk("pfx_e0", ev_valid, 0);
        send_ev(8'h75, 10'h275);
        send(8'hE0);
        send(8'hF0);
        chk("pfx_e0f0", ev_valid, 0);
        send_ev(8'h75, 10'h375);
        chk("lat_ext_brk", ev_valid, 1);
        send(8'hFA);
        chk("drop_fa", ev_valid, 0);
        send(8'hAA);
        chk("drop_aa", ev_valid, 0);
        // pause
        for (int i = 0; i < 7; i++) begin
            send(pause_seq[i]);
            chk("pause_pfx", ev_valid, 0);
        end
        send_ev(8'h77, 10'h2E1);
        chk("pause_ev", ev_valid, 1);
        // timeout
        send(8'hF0);
        pulses = 0; first = 0; seen_ev = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                pulses++;
                if (first == 0) first = i;
            end
            seen_ev |= ev_valid;
        end
        chk("tmo_pulses", pulses, 1);
        chk("tmo_when", first, 17);
        chk("tmo_noev", seen_ev, 0);
        send_ev(8'h1C, 10'h01C);
        chk("tmo_after", ev_valid, 1);
        repeat (2) @(posedge clk);
        #1 ev_ready = 0;
        chk("empty", ev_valid, 0);
        // fill, overflow, clear
        send_ev(8'h1C, 10'h01C);
        send_ev(8'h1B, 10'h01B);
        chk("rxen_c2", rx_en, 1);
        send_ev(8'h23, 10'h023);
        chk("rxen_c3", rx_en, 0);
        send_ev(8'h2B, 10'h02B);
        chk("ovf_c4", overflow, 0);
        send(8'h34);
        chk("ovf_set", overflow, 1);
        @(posedge clk); #1 clr_overflow = 1;
        @(posedge clk); #1 clr_overflow = 0;
        chk("ovf_clr", overflow, 0);
        @(posedge clk); #1 clr_overflow = 1; rx_done_tick = 1; rx_data = 8'h44;
        @(posedge clk); #1 clr_overflow = 0; rx_done_tick = 0;
        chk("ovf_set_wins", overflow, 1);
        @(posedge clk); #1 clr_overflow = 1;
        @(posedge clk); #1 clr_overflow = 0;
        chk("ovf_clr2", overflow, 0);
        chk("head_hold", {ev_ext, ev_break, ev_code}, 10'h01C);
        // push and pop together while full
        @(posedge clk); #1 ev_ready = 1; rx_done_tick = 1; rx_data = 8'h35; q.push_back(10'h035);
        @(posedge clk); #1 ev_ready = 0; rx_done_tick = 0;
        chk("full_pp_ovf", overflow, 0);
        chk("full_pp_rxen", rx_en, 0);
        chk("full_pp_head", {ev_ext, ev_break, ev_code}, 10'h01B);
        // drain
        @(posedge clk); #1 ev_ready = 1;
        @(posedge clk); #1 chk("drain_c3", rx_en, 0);
        @(posedge clk); #1 chk("drain_c2", rx_en, 1);
        for (int i = 0; i < 20 && (q.size() != 0 || ev_valid); i++) @(posedge clk);
        #1;
        chk("drain_sb", q.size(), 0);
        chk("drain_valid", ev_valid, 0);
        // reset in the middle of an extended sequence
        send(8'hE0);
        @(posedge clk); #1 reset = 0;
        #2;
        chk("mid_rst_valid", ev_valid, 0);
        chk("mid_rst_rxen", rx_en, 1);
        @(posedge clk); #1 reset = 1;
        send_ev(8'h75, 10'h075);
        chk("post_rst_ev", ev_valid, 1);
        repeat (3) @(posedge clk);
        #1 chk("sb_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
